// File: rtl/xmakina_prefetch_m_if.sv
// Bus bundle for xmakina_prefetch_m: flush/redirect, memory read port and decoder handshake.
// slave = prefetch queue side, master = CPU/memory environment side.
interface xmakina_prefetch_m_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 16
);
  logic              flush;
  logic [ADDR_W-1:0] flush_addr;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_done;
  logic [DATA_W-1:0] mem_rd_data;
  logic              instr_valid;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_addr;
  logic              instr_ack;
  logic [15:0]       stat_flush_cnt;
  logic [15:0]       stat_discard_cnt;

  modport slave (
    input  flush, flush_addr, mem_rd_done, mem_rd_data, instr_ack,
    output mem_rd_en, mem_rd_addr, instr_valid, instr_data, instr_addr,
           stat_flush_cnt, stat_discard_cnt
  );

  modport master (
    output flush, flush_addr, mem_rd_done, mem_rd_data, instr_ack,
    input  mem_rd_en, mem_rd_addr, instr_valid, instr_data, instr_addr,
           stat_flush_cnt, stat_discard_cnt
  );
endinterface

// File: rtl/xmakina_prefetch_m.sv
// Instruction prefetch queue: sequential reads ahead of the CPU into a fall-through FIFO.
// Optional flush/discard statistics counters enabled by XMAKINA_PREFETCH_STATS_EN.
module xmakina_prefetch_m #(
  parameter int unsigned       DEPTH      = 4,
  parameter int unsigned       ADDR_W     = 15,
  parameter int unsigned       DATA_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input logic                clk,
  input logic                reset,
  xmakina_prefetch_m_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_q, fetch_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_en_q, rd_en_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
  logic [DATA_W-1:0] fifo_data_q [DEPTH];
  logic              push, pop;

  always_comb begin
    state_d   = state_q;
    fetch_d   = fetch_q;
    rd_en_d   = rd_en_q;
    rd_addr_d = rd_addr_q;
    push      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.flush) begin
          fetch_d = bus.flush_addr;
        end else if (count_q < DEPTH_C) begin
          rd_en_d   = 1'b1;
          rd_addr_d = fetch_q;
          state_d   = REQ;
        end
      end
      REQ: begin
        // Flush wins over a coincident completion; the returned word is dropped.
        if (bus.flush) begin
          fetch_d = bus.flush_addr;
          if (bus.mem_rd_done) begin
            rd_en_d = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = DISCARD;
          end
        end else if (bus.mem_rd_done) begin
          push    = 1'b1;
          fetch_d = fetch_q + ADDR_W'(1);
          rd_en_d = 1'b0;
          state_d = IDLE;
        end
      end
      DISCARD: begin
        if (bus.flush) fetch_d = bus.flush_addr;
        if (bus.mem_rd_done) begin
          rd_en_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pop      = bus.instr_ack && (count_q != '0) && !bus.flush;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + (PTR_W+1)'(1);
      else if (pop && !push) count_d = count_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      fetch_q   <= RESET_ADDR;
      rd_en_q   <= 1'b0;
      rd_addr_q <= RESET_ADDR;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      fetch_q   <= fetch_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= rd_addr_q;
      fifo_data_q[wr_ptr_q] <= bus.mem_rd_data;
    end
  end

  assign bus.mem_rd_en   = rd_en_q;
  assign bus.mem_rd_addr = rd_addr_q;
  assign bus.instr_valid = (count_q != '0);
  assign bus.instr_data  = (count_q != '0) ? fifo_data_q[rd_ptr_q] : '0;
  assign bus.instr_addr  = (count_q != '0) ? fifo_addr_q[rd_ptr_q] : '0;

`ifdef XMAKINA_PREFETCH_STATS_EN
  logic [15:0] flush_cnt_q, discard_cnt_q;
  logic        drop;

  assign drop = bus.mem_rd_done &&
                ((state_q == DISCARD) || ((state_q == REQ) && bus.flush));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flush_cnt_q   <= '0;
      discard_cnt_q <= '0;
    end else begin
      if (bus.flush && (flush_cnt_q != '1))  flush_cnt_q   <= flush_cnt_q + 16'd1;
      if (drop && (discard_cnt_q != '1))     discard_cnt_q <= discard_cnt_q + 16'd1;
    end
  end

  assign bus.stat_flush_cnt   = flush_cnt_q;
  assign bus.stat_discard_cnt = discard_cnt_q;
`else
  assign bus.stat_flush_cnt   = '0;
  assign bus.stat_discard_cnt = '0;
`endif
endmodule

// File: tb/tb_xmakina_prefetch_m.sv
// Randomized bench for xmakina_prefetch_m against a transaction-level queue model.
module tb_xmakina_prefetch_m;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 16;

  logic clk;
  logic reset;

  xmakina_prefetch_m_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  xmakina_prefetch_m #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_ADDR(15'h0000)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks;
  int unsigned n_errors;

  // Reference model: delivered-word queue plus the single outstanding read.
  logic [14:0] m_qa [$];
  logic [15:0] m_qd [$];
  logic [14:0] m_ptr;
  logic [14:0] m_req;
  bit          m_out;
  bit          m_stale;
  int unsigned m_age;
  int unsigned m_lat;
  bit          m_rand_lat;
  logic [15:0] m_salt;
  int unsigned m_flushes;
  int unsigned m_discards;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_qa.delete();
    m_qd.delete();
    m_ptr = 15'h0000;
    m_req = 15'h0000;
    m_out = 0;
    m_stale = 0;
    m_age = 0;
    m_flushes = 0;
    m_discards = 0;
  endtask

  task automatic model_edge(input logic fl, input logic [14:0] fa, input logic ack,
                            input logic done, input logic [15:0] data);
    int unsigned size_before;
    size_before = m_qa.size();
    if (fl) begin
      m_qa.delete();
      m_qd.delete();
      m_ptr = fa;
      if (m_flushes < 16'hFFFF) m_flushes++;
      if (m_out && done) begin
        m_out = 0;
        if (m_discards < 16'hFFFF) m_discards++;
      end else if (m_out) begin
        m_stale = 1;
      end
    end else begin
      if (ack && size_before > 0) begin
        void'(m_qa.pop_front());
        void'(m_qd.pop_front());
      end
      if (m_out && done) begin
        if (m_stale) begin
          if (m_discards < 16'hFFFF) m_discards++;
        end else begin
          m_qa.push_back(m_req);
          m_qd.push_back(data);
          m_ptr = m_req + 15'h0001;
        end
        m_out = 0;
      end else if (!m_out && size_before < DEPTH) begin
        m_out = 1;
        m_stale = 0;
        m_req = m_ptr;
        m_age = 0;
        if (m_rand_lat) m_lat = $urandom_range(1, 4);
      end
    end
  endtask

  task automatic check_outputs();
    logic [15:0] exp_fl, exp_di;
    check_eq("rd_en", 32'(bus.mem_rd_en), 32'(m_out));
    if (m_out) check_eq("rd_addr", 32'(bus.mem_rd_addr), 32'(m_req));
    check_eq("valid", 32'(bus.instr_valid), 32'(m_qa.size() != 0));
    check_eq("head_addr", 32'(bus.instr_addr), (m_qa.size() != 0) ? 32'(m_qa[0]) : 32'd0);
    check_eq("head_data", 32'(bus.instr_data), (m_qd.size() != 0) ? 32'(m_qd[0]) : 32'd0);
`ifdef XMAKINA_PREFETCH_STATS_EN
    exp_fl = 16'(m_flushes);
    exp_di = 16'(m_discards);
`else
    exp_fl = 16'h0000;
    exp_di = 16'h0000;
`endif
    check_eq("stat_flush", 32'(bus.stat_flush_cnt), 32'(exp_fl));
    check_eq("stat_discard", 32'(bus.stat_discard_cnt), 32'(exp_di));
  endtask

  // One clock: called at a falling edge, checks, drives inputs, returns at the next falling edge.
  task automatic cycle(input logic fl, input logic [14:0] fa, input logic ack, input logic stray);
    logic        done;
    logic [15:0] data;
    check_outputs();
    done = stray;
    if (m_out) begin
      m_age++;
      if (m_age >= m_lat) begin
        done = 1'b1;
        m_age = 0;
      end
    end
    data = done ? (16'(m_req) ^ m_salt) : 16'($urandom);
    bus.flush       = fl;
    bus.flush_addr  = fa;
    bus.instr_ack   = ack;
    bus.mem_rd_done = done;
    bus.mem_rd_data = data;
    model_edge(fl, fa, ack, done, data);
    @(negedge clk);
  endtask

  initial begin
    bit found;
    n_checks = 0;
    n_errors = 0;
    clk = 0;
    reset = 0;
    bus.flush = 0;
    bus.flush_addr = '0;
    bus.instr_ack = 0;
    bus.mem_rd_done = 0;
    bus.mem_rd_data = '0;
    m_lat = 2;
    m_rand_lat = 0;
    m_salt = 16'h0000;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    check_eq("reset_rd_addr", 32'(bus.mem_rd_addr), 32'h0);
    reset = 1;

    // Sequential fill with no consumer.
    repeat (20) cycle(1'b0, 15'h0, 1'b0, 1'b0);
    check_eq("fill_head_addr", 32'(bus.instr_addr), 32'h0);
    check_eq("fill_rd_en", 32'(bus.mem_rd_en), 32'h0);

    // Streaming.
    repeat (40) cycle(1'b0, 15'h0, 1'b1, 1'b0);

    // Flush while a read has just been issued.
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_out && m_age == 0 && !m_stale) found = 1;
      else cycle(1'b0, 15'h0, 1'b0, 1'b0);
    end
    check_eq("wait_pending", 32'(found), 32'h1);
    cycle(1'b1, 15'h0100, 1'b0, 1'b0);
    repeat (15) cycle(1'b0, 15'h0, 1'b0, 1'b0);

    // Flush, done and ack in the same cycle.
    repeat (6) cycle(1'b0, 15'h0, 1'b1, 1'b0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_out && m_age == m_lat - 1 && !m_stale && m_qa.size() != 0) found = 1;
      else cycle(1'b0, 15'h0, 1'b0, 1'b0);
    end
    check_eq("wait_done_edge", 32'(found), 32'h1);
    cycle(1'b1, 15'h0200, 1'b1, 1'b0);
    repeat (10) cycle(1'b0, 15'h0, 1'b0, 1'b0);

    // Address wrap.
    cycle(1'b1, 15'h7FFE, 1'b1, 1'b0);
    repeat (24) cycle(1'b0, 15'h0, 1'b1, 1'b0);

    // Reset while a read is outstanding, then a stray completion.
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_out) found = 1;
      else cycle(1'b0, 15'h0, 1'b0, 1'b0);
    end
    check_eq("wait_read", 32'(found), 32'h1);
    bus.mem_rd_done = 0;
    bus.instr_ack = 0;
    bus.flush = 0;
    #2 reset = 0;
    #1;
    model_reset();
    check_outputs();
    check_eq("rst_rd_addr", 32'(bus.mem_rd_addr), 32'h0);
    @(negedge clk);
    reset = 1;
    cycle(1'b0, 15'h0, 1'b0, 1'b1);
    repeat (12) cycle(1'b0, 15'h0, 1'b0, 1'b0);

    // Randomized traffic.
    m_rand_lat = 1;
    for (int i = 0; i < 600; i++) begin
      logic        fl, ack;
      logic [14:0] fa;
      m_salt = 16'($urandom);
      fl  = ($urandom_range(0, 15) == 0);
      ack = ($urandom_range(0, 1) == 1);
      fa  = ($urandom_range(0, 3) == 0) ? 15'(15'h7FFC + 15'($urandom_range(0, 5)))
                                        : 15'($urandom);
      cycle(fl, fa, ack, 1'b0);
    end
    check_outputs();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
